timer_multi_ch: RTL
===================

// Module: timer_multi_ch
// PURPOSE
//  NUM_CH independent down-counting timers sharing one clock and prescale value.
//  Per channel: one-shot or auto-reload, pause/resume, stretched interrupt line.
//  Sits between the register/bus interface (drives the control inputs) and the
//  interrupt controller (consumes irq / irq_any).
//  Generalises the single-channel timer control unit: adds width, channels,
//  prescaler, pause and a parametrised IRQ hold.
// PARAMETERS
//  NUM_CH    4   number of timer channels (1..16)
//  CNT_W     32  counter / load value width in bits
//  PRESC_W   8   prescale value width in bits
//  IRQ_HOLD  16  cycles each irq[i] stays high per expiry (>=1)
// PORTS
//  clk          in   1             single clock, all logic on posedge
//  rst          in   1             synchronous reset, active-high
//  prescale     in   PRESC_W       tick every prescale+1 clk cycles (0 = every cycle)
//  timer_en     in   NUM_CH        per-channel enable; low forces IDLE
//  start        in   NUM_CH        1-cycle pulse: load load_val and run
//  pause        in   NUM_CH        level: freeze counter and prescaler while high
//  auto_reload  in   NUM_CH        1 = reload on expiry, 0 = one-shot
//  int_en       in   NUM_CH        enable irq generation on expiry
//  load_val     in   NUM_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]
//  count        out  NUM_CH        channel in RUN or PAUSE
//  cnt_val      out  NUM_CH*CNT_W  current counter value, same packing
//  done         out  NUM_CH        1-cycle pulse per expiry (regardless of int_en)
//  irq          out  NUM_CH        stretched interrupt, IRQ_HOLD cycles
//  irq_any      out  1             OR of irq
// BEHAVIOUR
//  - Reset: all outputs 0, all channels IDLE, prescalers and irq hold counters 0.
//  - States per channel: IDLE, RUN, PAUSE.
//    IDLE->RUN on start & timer_en. RUN<->PAUSE follows pause.
//    RUN->IDLE on one-shot expiry. Any state->IDLE when timer_en low.
//  - start (with timer_en): next cycle cnt_val=load_val, prescaler=0, count=1.
//    Accepted in any state (restart). In PAUSE, pause still applies.
//  - Tick: per-channel prescaler increments in RUN only; tick when it equals
//    prescale, then wraps to 0. In PAUSE, prescaler and counter hold.
//  - On tick: cnt_val!=0 -> decrement.
//    cnt_val==0 -> expiry: reload load_val (auto_reload) or go IDLE.
//  - Expiry -> done high the next cycle for 1 cycle.
//    If int_en is also set at expiry, irq high from that same cycle for
//    IRQ_HOLD cycles.
//  - Latency (prescale=0, load L): start in cycle N -> done in cycle N+L+2.
//    Period = (L+1)*(prescale+1) cycles.
//  - Re-expiry while irq is held restarts the hold count (no gap, no pulse count).
//  - irq hold is independent of state: it continues through timer_en low,
//    cleared only by rst.
//  - Simultaneous: rst > timer_en low > start > expiry.
//    start in the expiry cycle suppresses that expiry's done/irq.
//    load_val=0 expires on the first tick.
//  - Wrap: the counter never underflows; decrement only from nonzero.
//  - Changing prescale mid-run takes effect at the next compare.
//    If new prescale < prescaler, the prescaler wraps through 2^PRESC_W-1.
// STRUCTURE
//  - timer_pkg: state enum (TMR_IDLE/TMR_RUN/TMR_PAUSE), and a hold-counter
//    width function clog2(IRQ_HOLD+1).
//  - Sub-module timer_channel: one FSM, prescaler, counter and irq stretcher.
//    Instantiated NUM_CH times via generate.
//  - Top: port slicing and irq_any OR-reduce.
// TESTING
//  1. One-shot, prescale=0, load=5, int_en=1, start@N -> done@N+7;
//     irq high N+7..N+22; count low from N+7.
//  2. auto_reload, prescale=3, load=2 -> done every 12 cycles; cnt_val 2,1,0 repeating.
//  3. pause for 10 cycles mid-run -> expiry delayed exactly 10 cycles;
//     cnt_val frozen while paused.
//  4. start asserted in the expiry cycle -> no done/irq;
//     cnt_val=load_val next cycle; full period follows.
//  5. timer_en low mid-run -> IDLE and count=0 next cycle; an active irq hold completes;
//     rst mid-run -> all outputs 0 next cycle.
//  6. NUM_CH=4 with different loads and int_en=0 on ch2 -> ch2 pulses done but never irq;
//     irq_any = OR of the rest.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel timer.
package timer_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE  = 2'd0,
    TMR_RUN   = 2'd1,
    TMR_PAUSE = 2'd2
  } tmr_state_e;

  // Width of a counter that must hold values 0..hold inclusive.
  function automatic int hold_w(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/PAUSE FSM, prescaler, down-counter and irq stretcher.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int PRESC_W  = 8,
  parameter int IRQ_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               timer_en,
  input  logic               start,
  input  logic               pause,
  input  logic               auto_reload,
  input  logic               int_en,
  input  logic [CNT_W-1:0]   load_val,
  output logic               count,
  output logic [CNT_W-1:0]   cnt_val,
  output logic               done,
  output logic               irq
);

  localparam int HOLD_W = hold_w(IRQ_HOLD);

  tmr_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic                active, tick, expire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    hold_d  = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
    done_d  = 1'b0;
    tick    = 1'b0;
    expire  = 1'b0;

    // Counting is gated directly by the pause level so the freeze matches it cycle for cycle.
    active = (state_q != TMR_IDLE) && !pause;

    if (active) begin
      if (presc_q == prescale) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (tick) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else             expire = 1'b1;
    end

    if (state_q != TMR_IDLE) state_d = pause ? TMR_PAUSE : TMR_RUN;

    if (expire && !start && timer_en) begin
      done_d = 1'b1;
      if (int_en) hold_d = HOLD_W'(IRQ_HOLD);
      if (auto_reload) cnt_d = load_val;
      else             state_d = TMR_IDLE;
    end

    if (start && timer_en) begin
      cnt_d   = load_val;
      presc_d = '0;
      state_d = pause ? TMR_PAUSE : TMR_RUN;
    end

    // Disable wins over everything except reset; the irq hold keeps draining.
    if (!timer_en) begin
      state_d = TMR_IDLE;
      cnt_d   = cnt_q;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TMR_IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign count   = (state_q != TMR_IDLE);
  assign cnt_val = cnt_q;
  assign done    = done_q;
  assign irq     = (hold_q != '0);

endmodule

// File: rtl/timer_multi_ch.sv
// NUM_CH independent down-counting timers sharing a clock and prescale value.
module timer_multi_ch
  import timer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int PRESC_W  = 8,
  parameter int IRQ_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [NUM_CH-1:0]         timer_en,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         pause,
  input  logic [NUM_CH-1:0]         auto_reload,
  input  logic [NUM_CH-1:0]         int_en,
  input  logic [NUM_CH*CNT_W-1:0]   load_val,
  output logic [NUM_CH-1:0]         count,
  output logic [NUM_CH*CNT_W-1:0]   cnt_val,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         irq,
  output logic                      irq_any
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W    (CNT_W),
      .PRESC_W  (PRESC_W),
      .IRQ_HOLD (IRQ_HOLD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .prescale    (prescale),
      .timer_en    (timer_en[i]),
      .start       (start[i]),
      .pause       (pause[i]),
      .auto_reload (auto_reload[i]),
      .int_en      (int_en[i]),
      .load_val    (load_val[i*CNT_W +: CNT_W]),
      .count       (count[i]),
      .cnt_val     (cnt_val[i*CNT_W +: CNT_W]),
      .done        (done[i]),
      .irq         (irq[i])
    );
  end

  assign irq_any = |irq;

endmodule
